md_iteration_sequencer: RTL

// Top-level sequencer for the range-limited MD loop. Runs N timesteps of broadcast/force-evaluation then motion update.

---
 rtl/md_iteration_sequencer_if.sv | 39 +++
 rtl/md_iteration_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/md_iteration_sequencer_if.sv
// Handshake bundle between the MD iteration sequencer and its neighbours
// (broadcast controller, ring, force caches, motion update control).
interface md_iteration_sequencer_if #(
  parameter int NUM_CELLS  = 64,
  parameter int ITER_WIDTH = 16
);
  logic                  start;
  logic [ITER_WIDTH-1:0] num_iterations;
  logic                  all_reading_done;
  logic [NUM_CELLS-1:0]  ref_wb_issued;
  logic                  goto_next_ref;
  logic [NUM_CELLS-1:0]  force_wr_enable;
  logic                  force_cache_buf_empty;
  logic                  all_filter_buffer_empty;
  logic                  mu_done;

  logic                  iter_start;
  logic                  all_ref_wb_issued;
  logic                  all_force_wr_issued;
  logic                  motion_update_start;
  logic                  busy;
  logic                  done;
  logic [ITER_WIDTH-1:0] iter_count;
  logic                  timeout;

  modport master (
    output start, num_iterations, all_reading_done, ref_wb_issued, goto_next_ref,
           force_wr_enable, force_cache_buf_empty, all_filter_buffer_empty, mu_done,
    input  iter_start, all_ref_wb_issued, all_force_wr_issued, motion_update_start,
           busy, done, iter_count, timeout
  );

  modport slave (
    input  start, num_iterations, all_reading_done, ref_wb_issued, goto_next_ref,
           force_wr_enable, force_cache_buf_empty, all_filter_buffer_empty, mu_done,
    output iter_start, all_ref_wb_issued, all_force_wr_issued, motion_update_start,
           busy, done, iter_count, timeout
  );
endinterface

// File: rtl/md_iteration_sequencer.sv
// Runs N MD timesteps: launch broadcast, wait for force phase to retire, run motion update.
// Optional FORCE/MU watchdog enabled by defining ITER_WATCHDOG_EN.
module md_iteration_sequencer #(
  parameter int NUM_CELLS      = 64,
  parameter int DRAIN_CYCLES   = 64,
  parameter int ITER_WIDTH     = 16,
  parameter int WATCHDOG_LIMIT = 2**20
) (
  input logic                    clk,
  input logic                    rst,
  md_iteration_sequencer_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_FORCE, S_MU, S_FINISH} state_t;

  // Writeback tracker: collect one ref writeback per PE, then let the ring drain.
  logic [NUM_CELLS-1:0] r_issued;
  logic                 armed;
  logic [DW-1:0]        drain_cnt;
  logic                 interconnect_empty;
  logic                 force_retired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issued  <= '0;
      armed     <= 1'b0;
      drain_cnt <= '0;
    end else if (!armed) begin
      if (&r_issued) begin
        armed     <= 1'b1;
        drain_cnt <= '0;
      end else begin
        r_issued <= r_issued | bus.ref_wb_issued;
      end
    end else if (drain_cnt == DRAIN_MAX || bus.goto_next_ref) begin
      armed     <= 1'b0;
      r_issued  <= '0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  assign interconnect_empty = armed && (drain_cnt == DRAIN_MAX);
  assign force_retired      = ~|bus.force_wr_enable && bus.force_cache_buf_empty &&
                              bus.all_filter_buffer_empty && interconnect_empty;

  state_t                state, state_d;
  logic [ITER_WIDTH-1:0] target, target_d, cnt, cnt_d;
  logic                  iter_start_q, iter_start_d;
  logic                  mus_q, mus_d;
  logic                  done_q, done_d;
  logic                  wd_trip;

  always_comb begin
    state_d      = state;
    target_d     = target;
    cnt_d        = cnt;
    iter_start_d = 1'b0;
    mus_d        = 1'b0;
    done_d       = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        if (bus.num_iterations != '0) begin
          target_d = bus.num_iterations;
          cnt_d    = '0;
          state_d  = S_LAUNCH;
        end else begin
          done_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        iter_start_d = 1'b1;
        state_d      = S_FORCE;
      end
      S_FORCE: if (bus.all_reading_done && force_retired) begin
        mus_d   = 1'b1;
        state_d = S_MU;
      end
      S_MU: if (bus.mu_done) begin
        cnt_d   = cnt + 1'b1;
        state_d = (cnt_d == target) ? S_FINISH : S_LAUNCH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A watchdog trip abandons the run silently: no MU start, no done.
    if (wd_trip) begin
      state_d = S_IDLE;
      mus_d   = 1'b0;
      cnt_d   = cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      target       <= '0;
      cnt          <= '0;
      iter_start_q <= 1'b0;
      mus_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_d;
      target       <= target_d;
      cnt          <= cnt_d;
      iter_start_q <= iter_start_d;
      mus_q        <= mus_d;
      done_q       <= done_d;
    end
  end

`ifdef ITER_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_LIMIT + 1);
  logic [WW-1:0] wd_cnt;
  logic          timeout_q;
  logic          in_wd;

  assign in_wd   = (state == S_FORCE) || (state == S_MU);
  assign wd_trip = in_wd && (wd_cnt == WW'(WATCHDOG_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) timeout_q <= 1'b0;
      else if (wd_trip)                 timeout_q <= 1'b1;
      if (state_d != state && (state_d == S_FORCE || state_d == S_MU)) wd_cnt <= '0;
      else if (in_wd && !wd_trip)                                       wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_trip     = 1'b0;
  // Any legal (positive) limit keeps this low; the limit has no effect without the watchdog.
  assign bus.timeout = (WATCHDOG_LIMIT < 1);
`endif

  assign bus.iter_start          = iter_start_q;
  assign bus.motion_update_start = mus_q;
  assign bus.done                = done_q;
  assign bus.busy                = (state != S_IDLE);
  assign bus.iter_count          = cnt;
  assign bus.all_ref_wb_issued   = armed;
  assign bus.all_force_wr_issued = force_retired;
endmodule
